// File: rtl/mirfak_div_pkg.sv
// mirfak_div_pkg: shared command, state and constant definitions for the divider front-end
package mirfak_div_pkg;
  typedef enum logic [1:0] {CMD_DIV = 2'b00, CMD_DIVU = 2'b01, CMD_REM = 2'b10, CMD_REMU = 2'b11} cmd_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_RESP = 2'b10} state_e;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] MINUS_ONE = 32'hFFFF_FFFF;
  localparam int TAG_W = 66;
endpackage

// File: rtl/mirfak_div_cache.sv
// mirfak_div_cache: one-entry {op1, op2, cmd} tag plus result, with a combinational hit compare
module mirfak_div_cache
  import mirfak_div_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_result_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  output logic [31:0]      result_o
);
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic             valid_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (wr_i) begin
      tag_q    <= wr_tag_i;
      result_q <= wr_result_i;
      valid_q  <= 1'b1;
    end
  end
  assign hit_o    = valid_q && (tag_q == lk_tag_i);
  assign result_o = result_q;
endmodule

// File: rtl/mirfak_div_sequencer.sv
// mirfak_div_sequencer: latches divide requests, resolves RISC-V corner cases and cache hits
// locally, and otherwise runs the iterative divider through its enable/ack handshake.
module mirfak_div_sequencer
  import mirfak_div_pkg::*;
#(
  parameter bit ENABLE_FASTPATH = 1'b1,
  parameter bit ENABLE_CACHE    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [1:0]  req_cmd,
  input  logic        req_valid,
  input  logic        req_abort,
  output logic [31:0] resp_result,
  output logic        resp_ack,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic [1:0]  div_cmd,
  output logic        div_enable,
  output logic        div_abort,
  input  logic [31:0] div_result,
  input  logic        div_ack
);
  state_e      state_q, state_d;
  logic [31:0] op1_q, op2_q, result_q, result_d;
  logic [1:0]  cmd_q;
  logic [31:0] fast_result, cache_result;
  logic        accept, by_zero, overflow, fast, hit, cache_hit, done;
  assign accept = (state_q == S_IDLE) && req_valid && !req_abort;
  assign done   = (state_q == S_BUSY) && div_ack && !req_abort;
  assign by_zero  = req_op2 == '0;
  assign overflow = (req_op1 == INT_MIN) && (req_op2 == MINUS_ONE) &&
                    (cmd_e'(req_cmd) == CMD_DIV || cmd_e'(req_cmd) == CMD_REM);
  assign fast     = ENABLE_FASTPATH && (by_zero || overflow);
  assign hit      = ENABLE_CACHE && cache_hit;
  // Division by zero outranks overflow: INT_MIN / 0 is still a divide-by-zero.
  assign fast_result = by_zero ? (req_cmd[1] ? req_op1 : DIV_BY_ZERO_Q)
                               : (cmd_e'(req_cmd) == CMD_DIV ? INT_MIN : 32'h0);
  mirfak_div_cache u_cache (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_i        (done),
    .wr_tag_i    ({op1_q, op2_q, cmd_q}),
    .wr_result_i (div_result),
    .lk_tag_i    ({req_op1, req_op2, req_cmd}),
    .hit_o       (cache_hit),
    .result_o    (cache_result)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = req_abort                            ? S_IDLE
            : (state_q == S_IDLE && req_valid)     ? ((fast || hit) ? S_RESP : S_BUSY)
            : (state_q == S_BUSY)                  ? (div_ack ? S_RESP : S_BUSY)
            : S_IDLE;
  end
  always_comb begin
    resp_ack   = (state_q == S_RESP) && !req_abort;
    div_enable = state_q == S_BUSY;
    div_abort  = req_abort;
  end
  assign result_d = (accept && fast) ? fast_result
                  : (accept && hit)  ? cache_result
                  : done             ? div_result
                  : result_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op1_q <= req_op1;
        op2_q <= req_op2;
        cmd_q <= req_cmd;
      end
      result_q <= result_d;
    end
  end
  assign resp_result = result_q;
  assign div_op1     = op1_q;
  assign div_op2     = op2_q;
  assign div_cmd     = cmd_q;
endmodule

// File: tb/tb_mirfak_div_sequencer.sv
// tb_mirfak_div_sequencer: directed requests against a behavioural RISC-V divide and cache model,
// with a per-cycle compare of the handshake and result outputs.
module tb_mirfak_div_sequencer;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] req_op1 = '0, req_op2 = '0, div_result = 32'hDEAD_BEEF;
  logic [1:0]  req_cmd = '0;
  logic        req_valid = 1'b0, req_abort = 1'b0, div_ack = 1'b0;
  logic [31:0] resp_result, div_op1, div_op2;
  logic [1:0]  div_cmd;
  logic        resp_ack, div_enable, div_abort;
  int          n_tests = 0, n_fail = 0;
  bit          chk_on = 1'b0;
  logic        exp_ack = 1'b0, exp_en = 1'b0;
  logic [31:0] exp_res = '0, cur_a = '0, cur_b = '0;
  logic [1:0]  cur_c = '0;
  logic        cvalid = 1'b0;
  logic [31:0] ca = '0, cb = '0;
  logic [1:0]  cc = '0;

  mirfak_div_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_op1(req_op1), .req_op2(req_op2), .req_cmd(req_cmd),
    .req_valid(req_valid), .req_abort(req_abort), .resp_result(resp_result), .resp_ack(resp_ack),
    .div_op1(div_op1), .div_op2(div_op2), .div_cmd(div_cmd), .div_enable(div_enable),
    .div_abort(div_abort), .div_result(div_result), .div_ack(div_ack)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'h0 : 32'h8000_0000;
    case (c)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  always @(negedge clk_i) if (chk_on) begin
    check("resp_ack", {31'b0, resp_ack}, {31'b0, exp_ack});
    check("div_enable", {31'b0, div_enable}, {31'b0, exp_en});
    check("div_abort", {31'b0, div_abort}, {31'b0, req_abort});
    check("resp_result", resp_result, exp_res);
    if (exp_en) begin
      check("div_op1", div_op1, cur_a);
      check("div_op2", div_op2, cur_b);
      check("div_cmd", {30'b0, div_cmd}, {30'b0, cur_c});
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // abort_at >= 0 aborts in that BUSY cycle; abort_ack aborts in the div_ack cycle.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                     input int lat, input int abort_at, input bit abort_ack);
    logic [31:0] r;
    bit local_path;
    r = ref_div(a, b, c);
    local_path = (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && !c[0]) ||
                 (cvalid && ca == a && cb == b && cc == c);
    cur_a = a; cur_b = b; cur_c = c;
    req_op1 = a; req_op2 = b; req_cmd = c; req_valid = 1'b1;
    step();
    if (local_path) begin
      exp_ack = 1'b1; exp_res = r;
      step();
      req_valid = 1'b0; exp_ack = 1'b0;
      step();
      return;
    end
    exp_en = 1'b1;
    for (int i = 0; i < lat; i++) begin
      if (i == abort_at) begin
        req_abort = 1'b1;
        step();
        req_abort = 1'b0; req_valid = 1'b0; exp_en = 1'b0;
        step();
        return;
      end
      step();
    end
    div_ack = 1'b1; div_result = r; req_abort = abort_ack;
    step();
    div_ack = 1'b0; div_result = 32'hDEAD_BEEF; req_abort = 1'b0; exp_en = 1'b0;
    if (abort_ack) begin
      req_valid = 1'b0;
      step();
      return;
    end
    exp_ack = 1'b1; exp_res = r;
    cvalid = 1'b1; ca = a; cb = b; cc = c;
    step();
    req_valid = 1'b0; exp_ack = 1'b0;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_resp_ack", {31'b0, resp_ack}, 32'h0);
    check("rst_div_enable", {31'b0, div_enable}, 32'h0);
    check("rst_resp_result", resp_result, 32'h0);
    check("rst_div_op1", div_op1, 32'h0);
    check("rst_div_op2", div_op2, 32'h0);
    check("rst_div_cmd", {30'b0, div_cmd}, 32'h0);
    req_abort = 1'b1;
    #1 check("rst_div_abort", {31'b0, div_abort}, 32'h1);
    req_abort = 1'b0;
    rst_i = 1'b0;
    check("model_divu", ref_div(100, 7, 2'b01), 32'd14);
    check("model_div0", ref_div(5, 0, 2'b00), 32'hFFFF_FFFF);
    check("model_remu0", ref_div(5, 0, 2'b11), 32'd5);
    check("model_ovf_div", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 2'b00), 32'h8000_0000);
    check("model_ovf_rem", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 2'b10), 32'h0);
    check("model_div_neg", ref_div(-32'sd7, 2, 2'b00), 32'hFFFF_FFFD);
    check("model_rem_neg", ref_div(-32'sd7, 2, 2'b10), 32'hFFFF_FFFF);
    check("model_divu_big", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 2'b01), 32'h0);
    chk_on = 1'b1;
    step();
    run(100, 7, 2'b01, 3, -1, 1'b0);
    run(100, 7, 2'b01, 3, -1, 1'b0);
    run(100, 7, 2'b00, 2, -1, 1'b0);
    run(5, 0, 2'b00, 2, -1, 1'b0);
    run(5, 0, 2'b11, 2, -1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2, -1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 2, -1, 1'b0);
    run(100, 7, 2'b00, 2, -1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 1, -1, 1'b0);
    run(-32'sd7, 2, 2'b10, 4, 1, 1'b0);
    run(-32'sd7, 2, 2'b10, 2, -1, 1'b0);
    run(1000, -32'sd3, 2'b00, 2, -1, 1'b1);
    run(-32'sd7, 2, 2'b10, 2, -1, 1'b0);
    run(1000, -32'sd3, 2'b00, 0, -1, 1'b0);
    req_op1 = 77; req_op2 = 11; req_cmd = 2'b01; req_valid = 1'b1; req_abort = 1'b1;
    step();
    req_abort = 1'b0; req_valid = 1'b0;
    step();
    cur_a = 9; cur_b = 3; cur_c = 2'b01;
    req_op1 = 9; req_op2 = 3; req_cmd = 2'b01; req_valid = 1'b1;
    step();
    exp_en = 1'b1;
    @(negedge clk_i);
    #1 chk_on = 1'b0;
    rst_i = 1'b1;
    #1;
    check("async_rst_div_enable", {31'b0, div_enable}, 32'h0);
    check("async_rst_resp_ack", {31'b0, resp_ack}, 32'h0);
    check("async_rst_resp_result", resp_result, 32'h0);
    req_valid = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    exp_en = 1'b0; exp_ack = 1'b0; exp_res = '0; cvalid = 1'b0;
    chk_on = 1'b1;
    step();
    run(100, 7, 2'b01, 2, -1, 1'b0);
    run(100, 7, 2'b01, 2, -1, 1'b0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
